// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the instruction address, runs the req/ack handshake with the
// I-cache and presents one fetched instruction per cycle with its PSTATE, stall/redirect/fault aware.
module instr_fetch_unit #(
  parameter int unsigned           WORD_LENGTH  = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_IA_OFS = 32'h0,
  parameter logic [15:0]            RESET_STATUS = 16'h0,
  parameter logic [WORD_LENGTH-1:0] BUBBLE_INSTR = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inStall,
  input  logic                   inRedirect,
  input  logic [31:0]            inRedirectPstate0,
  input  logic [WORD_LENGTH-1:0] inRedirectPstate1,
  output logic                   outIcReq,
  output logic [15:0]            outIcSeg,
  output logic [WORD_LENGTH-1:0] outIcOfs,
  input  logic                   inIcAck,
  input  logic                   inIcErr,
  input  logic [WORD_LENGTH-1:0] inIcData,
  output logic [31:0]            outPstate0,
  output logic [WORD_LENGTH-1:0] outPstate1,
  output logic [WORD_LENGTH-1:0] outInstr,
  output logic                   outValid,
  output logic                   outTrap
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_FLUSH, S_TRAP} state_e;

  localparam logic [WORD_LENGTH-1:0] OFS_STEP  = WORD_LENGTH'(4);
  localparam logic [WORD_LENGTH-1:0] ALIGN_MSK = ~WORD_LENGTH'(3);

  state_e                 state_q,     state_d;
  logic [31:0]            ia_pst0_q,   ia_pst0_d;
  logic [WORD_LENGTH-1:0] ia_ofs_q,    ia_ofs_d;
  logic                   ic_req_q,    ic_req_d;
  logic [15:0]            ic_seg_q,    ic_seg_d;
  logic [WORD_LENGTH-1:0] ic_ofs_q,    ic_ofs_d;
  logic [31:0]            out_pst0_q,  out_pst0_d;
  logic [WORD_LENGTH-1:0] out_pst1_q,  out_pst1_d;
  logic [WORD_LENGTH-1:0] out_instr_q, out_instr_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_trap_q,  out_trap_d;
  logic [31:0]            hold_pst0_q, hold_pst0_d;
  logic [WORD_LENGTH-1:0] hold_pst1_q, hold_pst1_d;
  logic [WORD_LENGTH-1:0] hold_instr_q, hold_instr_d;

  logic                   ack_v;
  logic [WORD_LENGTH-1:0] ia_ofs_inc;
  logic [WORD_LENGTH-1:0] redir_ofs;

  assign ack_v      = ic_req_q & inIcAck;
  assign ia_ofs_inc = ia_ofs_q + OFS_STEP;
  assign redir_ofs  = inRedirectPstate1 & ALIGN_MSK;

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through this block can infer a latch.
    state_d      = state_q;
    ia_pst0_d    = ia_pst0_q;
    ia_ofs_d     = ia_ofs_q;
    ic_req_d     = ic_req_q;
    ic_seg_d     = ic_seg_q;
    ic_ofs_d     = ic_ofs_q;
    out_pst0_d   = out_pst0_q;
    out_pst1_d   = out_pst1_q;
    out_instr_d  = out_instr_q;
    out_valid_d  = out_valid_q;
    out_trap_d   = out_trap_q;
    hold_pst0_d  = hold_pst0_q;
    hold_pst1_d  = hold_pst1_q;
    hold_instr_d = hold_instr_q;

    if (inRedirect) begin
      ia_pst0_d    = inRedirectPstate0;
      ia_ofs_d     = redir_ofs;
      out_valid_d  = 1'b0;
      out_trap_d   = 1'b0;
      out_instr_d  = BUBBLE_INSTR;
      hold_pst0_d  = '0;
      hold_pst1_d  = '0;
      hold_instr_d = '0;
      // An unanswered request must keep its address until the cache acks it.
      if (ic_req_q && !inIcAck) begin
        state_d = S_FLUSH;
      end else begin
        state_d  = S_REQ;
        ic_req_d = 1'b1;
        ic_seg_d = inRedirectPstate0[15:0];
        ic_ofs_d = redir_ofs;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (ack_v && inIcErr) begin
            state_d  = S_TRAP;
            ic_req_d = 1'b0;
            if (!inStall) begin
              out_trap_d  = 1'b1;
              out_valid_d = 1'b0;
              out_pst0_d  = ia_pst0_q;
              out_pst1_d  = ia_ofs_q;
              out_instr_d = BUBBLE_INSTR;
            end
          end else if (ack_v) begin
            ia_ofs_d = ia_ofs_inc;
            if (!inStall) begin
              out_valid_d = 1'b1;
              out_pst0_d  = ia_pst0_q;
              out_pst1_d  = ia_ofs_q;
              out_instr_d = inIcData;
              ic_req_d    = 1'b1;
              ic_seg_d    = ia_pst0_q[15:0];
              ic_ofs_d    = ia_ofs_inc;
            end else begin
              state_d      = S_HOLD;
              ic_req_d     = 1'b0;
              hold_pst0_d  = ia_pst0_q;
              hold_pst1_d  = ia_ofs_q;
              hold_instr_d = inIcData;
            end
          end else begin
            if (!inStall) begin
              out_valid_d = 1'b0;
              out_instr_d = BUBBLE_INSTR;
            end
            ic_req_d = 1'b1;
            ic_seg_d = ia_pst0_q[15:0];
            ic_ofs_d = ia_ofs_q;
          end
        end
        S_HOLD: begin
          if (!inStall) begin
            out_valid_d = 1'b1;
            out_pst0_d  = hold_pst0_q;
            out_pst1_d  = hold_pst1_q;
            out_instr_d = hold_instr_q;
            state_d     = S_REQ;
            ic_req_d    = 1'b1;
            ic_seg_d    = ia_pst0_q[15:0];
            ic_ofs_d    = ia_ofs_q;
          end
        end
        S_FLUSH: begin
          // Whatever the stale request returns is dropped; only the ack matters.
          if (inIcAck) begin
            state_d  = S_REQ;
            ic_req_d = 1'b1;
            ic_seg_d = ia_pst0_q[15:0];
            ic_ofs_d = ia_ofs_q;
          end
        end
        S_TRAP: begin
          // IA still names the faulting word; publish it once the consumer can take it.
          if (!inStall) begin
            out_trap_d  = 1'b1;
            out_valid_d = 1'b0;
            out_pst0_d  = ia_pst0_q;
            out_pst1_d  = ia_ofs_q;
            out_instr_d = BUBBLE_INSTR;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      ia_pst0_q    <= {RESET_STATUS, 16'h0};
      ia_ofs_q     <= RESET_IA_OFS & ALIGN_MSK;
      ic_req_q     <= 1'b0;
      ic_seg_q     <= '0;
      ic_ofs_q     <= '0;
      out_pst0_q   <= '0;
      out_pst1_q   <= '0;
      out_instr_q  <= BUBBLE_INSTR;
      out_valid_q  <= 1'b0;
      out_trap_q   <= 1'b0;
      hold_pst0_q  <= '0;
      hold_pst1_q  <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      ia_pst0_q    <= ia_pst0_d;
      ia_ofs_q     <= ia_ofs_d;
      ic_req_q     <= ic_req_d;
      ic_seg_q     <= ic_seg_d;
      ic_ofs_q     <= ic_ofs_d;
      out_pst0_q   <= out_pst0_d;
      out_pst1_q   <= out_pst1_d;
      out_instr_q  <= out_instr_d;
      out_valid_q  <= out_valid_d;
      out_trap_q   <= out_trap_d;
      hold_pst0_q  <= hold_pst0_d;
      hold_pst1_q  <= hold_pst1_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign outIcReq   = ic_req_q;
  assign outIcSeg   = ic_seg_q;
  assign outIcOfs   = ic_ofs_q;
  assign outPstate0 = out_pst0_q;
  assign outPstate1 = out_pst1_q;
  assign outInstr   = out_instr_q;
  assign outValid   = out_valid_q;
  assign outTrap    = out_trap_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall/hold, redirect flush, redirect+ack,
// fetch fault and offset wrap, each with hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_stall;
  logic        in_redirect;
  logic [31:0] in_redirect_pstate0;
  logic [31:0] in_redirect_pstate1;
  logic        out_ic_req;
  logic [15:0] out_ic_seg;
  logic [31:0] out_ic_ofs;
  logic        in_ic_ack;
  logic        in_ic_err;
  logic [31:0] in_ic_data;
  logic [31:0] out_pstate0;
  logic [31:0] out_pstate1;
  logic [31:0] out_instr;
  logic        out_valid;
  logic        out_trap;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .inStall           (in_stall),
    .inRedirect        (in_redirect),
    .inRedirectPstate0 (in_redirect_pstate0),
    .inRedirectPstate1 (in_redirect_pstate1),
    .outIcReq          (out_ic_req),
    .outIcSeg          (out_ic_seg),
    .outIcOfs          (out_ic_ofs),
    .inIcAck           (in_ic_ack),
    .inIcErr           (in_ic_err),
    .inIcData          (in_ic_data),
    .outPstate0        (out_pstate0),
    .outPstate1        (out_pstate1),
    .outInstr          (out_instr),
    .outValid          (out_valid),
    .outTrap           (out_trap)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are read away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_stall = 1'b0; in_redirect = 1'b0;
    in_redirect_pstate0 = '0; in_redirect_pstate1 = '0;
    in_ic_ack = 1'b0; in_ic_err = 1'b0; in_ic_data = '0;
    step(); step();
    checks++;
    if ({out_ic_req, out_valid, out_trap} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got req/valid/trap=%b expected 000", {out_ic_req, out_valid, out_trap});
    end
    checks++;
    if ({out_pstate0, out_pstate1, out_instr} !== 96'h0) begin
      errors++; $display("FAIL reset_outs: got p0=%h p1=%h instr=%h expected all 0", out_pstate0, out_pstate1, out_instr);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({out_ic_req, out_ic_ofs} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL first_req: got req=%b ofs=%h expected 1/00000000", out_ic_req, out_ic_ofs);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_ic_ofs !== 32'(4 * i)) begin
        errors++; $display("FAIL stream_ofs%0d: got %h expected %h", i, out_ic_ofs, 32'(4 * i));
      end
      in_ic_ack = 1'b1; in_ic_data = 32'(i);
      step();
      checks++;
      if ({out_valid, out_instr, out_pstate1} !== {1'b1, 32'(i), 32'(4 * i)}) begin
        errors++; $display("FAIL stream_out%0d: got v=%b instr=%h p1=%h expected 1/%h/%h", i, out_valid, out_instr, out_pstate1, 32'(i), 32'(4 * i));
      end
    end
    in_ic_ack = 1'b0;
    step();
    checks++;
    if ({out_valid, out_ic_req, out_ic_ofs} !== {1'b0, 1'b1, 32'h10}) begin
      errors++; $display("FAIL stream_bubble: got v=%b req=%b ofs=%h expected 0/1/00000010", out_valid, out_ic_req, out_ic_ofs);
    end
  endtask

  task automatic test_stall();
    in_ic_ack = 1'b1; in_ic_data = 32'h4;
    step();
    in_stall = 1'b1; in_ic_data = 32'h5;
    step();
    in_ic_ack = 1'b0;
    checks++;
    if ({out_ic_req, out_valid, out_instr, out_pstate1} !== {1'b0, 1'b1, 32'h4, 32'h10}) begin
      errors++; $display("FAIL stall_enter: got req=%b v=%b instr=%h p1=%h expected 0/1/4/10", out_ic_req, out_valid, out_instr, out_pstate1);
    end
    step(); step();
    checks++;
    if ({out_ic_req, out_valid, out_instr} !== {1'b0, 1'b1, 32'h4}) begin
      errors++; $display("FAIL stall_frozen: got req=%b v=%b instr=%h expected 0/1/4", out_ic_req, out_valid, out_instr);
    end
    in_stall = 1'b0;
    step();
    checks++;
    if ({out_valid, out_instr, out_pstate1} !== {1'b1, 32'h5, 32'h14}) begin
      errors++; $display("FAIL stall_release: got v=%b instr=%h p1=%h expected 1/5/14", out_valid, out_instr, out_pstate1);
    end
    checks++;
    if ({out_ic_req, out_ic_ofs} !== {1'b1, 32'h18}) begin
      errors++; $display("FAIL stall_next_req: got req=%b ofs=%h expected 1/18", out_ic_req, out_ic_ofs);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_no_dup: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_redirect_flush();
    in_ic_ack = 1'b1; in_ic_data = 32'h99;
    for (int k = 0; k < 32 && out_ic_ofs !== 32'h40; k++) step();
    in_ic_ack = 1'b0;
    checks++;
    if (out_ic_ofs !== 32'h40) begin
      errors++; $display("FAIL flush_reach40: got ofs=%h expected 00000040", out_ic_ofs);
    end
    in_redirect = 1'b1; in_redirect_pstate0 = 32'h0001_0002; in_redirect_pstate1 = 32'h1003;
    step();
    in_redirect = 1'b0;
    checks++;
    if ({out_ic_req, out_ic_ofs, out_valid} !== {1'b1, 32'h40, 1'b0}) begin
      errors++; $display("FAIL flush_hold_old: got req=%b ofs=%h v=%b expected 1/40/0", out_ic_req, out_ic_ofs, out_valid);
    end
    step();
    in_ic_ack = 1'b1; in_ic_data = 32'hDEAD;
    step();
    in_ic_ack = 1'b0;
    checks++;
    if ({out_valid, out_instr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL flush_late_ack: got v=%b instr=%h expected 0/0", out_valid, out_instr);
    end
    checks++;
    if ({out_ic_req, out_ic_seg, out_ic_ofs} !== {1'b1, 16'h0002, 32'h1000}) begin
      errors++; $display("FAIL flush_new_req: got req=%b seg=%h ofs=%h expected 1/0002/1000", out_ic_req, out_ic_seg, out_ic_ofs);
    end
    step();
    in_ic_ack = 1'b1; in_ic_data = 32'h77;
    step();
    in_ic_ack = 1'b0;
    checks++;
    if ({out_valid, out_instr, out_pstate0, out_pstate1} !== {1'b1, 32'h77, 32'h0001_0002, 32'h1000}) begin
      errors++; $display("FAIL flush_first_instr: got v=%b instr=%h p0=%h p1=%h expected 1/77/00010002/1000", out_valid, out_instr, out_pstate0, out_pstate1);
    end
  endtask

  task automatic test_redirect_with_ack();
    in_ic_ack = 1'b1; in_ic_data = 32'hBAD;
    in_redirect = 1'b1; in_redirect_pstate0 = 32'h0003_0004; in_redirect_pstate1 = 32'h2000;
    step();
    in_ic_ack = 1'b0; in_redirect = 1'b0;
    checks++;
    if ({out_valid, out_instr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL redir_ack_drop: got v=%b instr=%h expected 0/0", out_valid, out_instr);
    end
    checks++;
    if ({out_ic_req, out_ic_seg, out_ic_ofs} !== {1'b1, 16'h0004, 32'h2000}) begin
      errors++; $display("FAIL redir_ack_req: got req=%b seg=%h ofs=%h expected 1/0004/2000", out_ic_req, out_ic_seg, out_ic_ofs);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_ack_bubble: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_trap();
    in_ic_ack = 1'b1; in_ic_data = 32'h0;
    in_redirect = 1'b1; in_redirect_pstate0 = 32'h0003_0004; in_redirect_pstate1 = 32'h80;
    step();
    in_redirect = 1'b0; in_ic_err = 1'b1;
    checks++;
    if (out_ic_ofs !== 32'h80) begin
      errors++; $display("FAIL trap_req80: got ofs=%h expected 00000080", out_ic_ofs);
    end
    step();
    in_ic_ack = 1'b0; in_ic_err = 1'b0;
    checks++;
    if ({out_trap, out_valid, out_pstate1, out_pstate0, out_ic_req} !== {1'b1, 1'b0, 32'h80, 32'h0003_0004, 1'b0}) begin
      errors++; $display("FAIL trap_out: got trap=%b v=%b p1=%h p0=%h req=%b expected 1/0/80/00030004/0", out_trap, out_valid, out_pstate1, out_pstate0, out_ic_req);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({out_trap, out_ic_req} !== 2'b10) begin
        errors++; $display("FAIL trap_wait%0d: got trap=%b req=%b expected 1/0", k, out_trap, out_ic_req);
      end
    end
  endtask

  task automatic test_wrap();
    in_redirect = 1'b1; in_redirect_pstate0 = 32'h0003_0004; in_redirect_pstate1 = 32'hFFFF_FFFC;
    step();
    in_redirect = 1'b0;
    checks++;
    if ({out_ic_req, out_ic_ofs, out_trap} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      errors++; $display("FAIL wrap_req: got req=%b ofs=%h trap=%b expected 1/fffffffc/0", out_ic_req, out_ic_ofs, out_trap);
    end
    in_ic_ack = 1'b1; in_ic_data = 32'h11;
    step();
    checks++;
    if ({out_valid, out_instr, out_pstate1, out_ic_ofs} !== {1'b1, 32'h11, 32'hFFFF_FFFC, 32'h0}) begin
      errors++; $display("FAIL wrap_first: got v=%b instr=%h p1=%h ofs=%h expected 1/11/fffffffc/0", out_valid, out_instr, out_pstate1, out_ic_ofs);
    end
    in_ic_data = 32'h22;
    step();
    in_ic_ack = 1'b0;
    checks++;
    if ({out_valid, out_instr, out_pstate1, out_pstate0} !== {1'b1, 32'h22, 32'h0, 32'h0003_0004}) begin
      errors++; $display("FAIL wrap_second: got v=%b instr=%h p1=%h p0=%h expected 1/22/0/00030004", out_valid, out_instr, out_pstate1, out_pstate0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_with_ack();
    test_trap();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
